// File: rtl/text_buffer.sv
// Purpose: 80x30 character frame store fed by a CPU byte stream; handles control codes, cursor and scrolling.
// Latency: pixel read path is 1 cycle (ascii_char, x_out, y_out, video_on_out registered together).
// Backpressure: wr_ready is high only in IDLE; CLEAR (COLS*ROWS cycles) and SCROLL_CLR (COLS cycles) stall the writer.
// Ports: clk/reset_n (async active-low); wr_valid/wr_data/wr_ready byte input; x/y/video_on pixel
//        position in; ascii_char/x_out/y_out/video_on_out to the glyph stage; cursor_col/cursor_row/busy status.
module text_buffer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       video_on,
  output logic [7:0] ascii_char,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       video_on_out,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, SCROLL_CLR, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [4:0]    top_row;
  logic [6:0]    cur_col;
  logic [4:0]    cur_row;

  logic [7:0]    mem [CELLS];

  logic          accept;
  logic          is_print;
  logic          last_col;
  logic          adv_row;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [4:0]    cur_phys;

  logic [6:0]    rd_col;
  logic [4:0]    rd_row;
  logic          rd_valid;
  logic [AW-1:0] raddr;

  // Logical row -> physical row through the circular top_row offset.
  function automatic logic [4:0] phys(input logic [4:0] r, input logic [4:0] t);
    logic [5:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] pr, input logic [6:0] c);
    return AW'(pr) * AW'(COLS) + AW'(c);
  endfunction

  assign wr_ready   = (state == IDLE);
  assign busy       = ~wr_ready;
  assign cursor_col = cur_col;
  assign cursor_row = cur_row;

  assign accept   = wr_valid & wr_ready;
  assign is_print = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
  assign last_col = (cur_col == 7'(COLS - 1));
  // Row advance comes from a line feed or from a printable wrapping past the last column.
  assign adv_row  = accept && ((is_print && last_col) || (wr_data == 8'h0A));
  assign cur_phys = phys(cur_row, top_row);

  // Single write port. During SCROLL_CLR the cursor sits on the bottom logical row and
  // top_row has already advanced, so cur_phys is the freshly exposed physical row.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = BLANK;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
      end
      SCROLL_CLR: begin
        we    = 1'b1;
        waddr = cell_addr(cur_phys, clr_cnt[6:0]);
      end
      default: begin
        if (accept && is_print) begin
          we    = 1'b1;
          waddr = cell_addr(cur_phys, cur_col);
          wdata = wr_data;
        end else if (accept && (wr_data == 8'h08) && (cur_col != 7'd0)) begin
          we    = 1'b1;
          waddr = cell_addr(cur_phys, cur_col - 7'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      top_row <= '0;
      cur_col <= '0;
      cur_row <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == AW'(CELLS - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        SCROLL_CLR: begin
          if (clr_cnt == AW'(COLS - 1)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            if (is_print) begin
              cur_col <= last_col ? 7'd0 : cur_col + 7'd1;
            end else if ((wr_data == 8'h0A) || (wr_data == 8'h0D)) begin
              cur_col <= '0;
            end else if ((wr_data == 8'h08) && (cur_col != 7'd0)) begin
              cur_col <= cur_col - 7'd1;
            end else if (wr_data == 8'h0C) begin
              state   <= CLEAR;
              clr_cnt <= '0;
              top_row <= '0;
              cur_col <= '0;
              cur_row <= '0;
            end
          end
          // Bottom row: scroll by rotating top_row instead of moving memory.
          if (adv_row) begin
            if (cur_row == 5'(ROWS - 1)) begin
              top_row <= (top_row == 5'(ROWS - 1)) ? 5'd0 : top_row + 5'd1;
              state   <= SCROLL_CLR;
              clr_cnt <= '0;
            end else begin
              cur_row <= cur_row + 5'd1;
            end
          end
        end
      endcase
    end
  end

  assign rd_col   = x[9:3];
  assign rd_row   = y[8:4];
  assign rd_valid = video_on && (rd_col < 7'(COLS)) && (rd_row < 5'(ROWS));
  assign raddr    = cell_addr(phys(rd_row, top_row), rd_col);

  // Read port is independent of the FSM; read-first against a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ascii_char   <= BLANK;
      x_out        <= '0;
      y_out        <= '0;
      video_on_out <= 1'b0;
    end else begin
      ascii_char   <= rd_valid ? mem[raddr] : BLANK;
      x_out        <= x;
      y_out        <= y;
      video_on_out <= video_on;
    end
  end

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character-cell frame store directly upstream of the glyph/pixel stage.
- Holds an 80x30 screen of 8-bit ASCII codes and accepts a byte stream from the CPU MMIO port over a valid/ready handshake.
- Interprets control codes, moves a cursor and scrolls.
- For every pixel coordinate from the VGA sync generator, supplies the cell's code plus coordinates delayed to match, so the glyph stage indexes glyph row y[3:0] and column x[2:0] (8x16 glyphs).

Parameters:
COLS, 80, characters per row (col = x[9:3])
ROWS, 30, character rows (row = y[8:4])
BLANK, 8'h20, code displayed for cleared or out-of-range cells

Ports:
clk  input  1  pixel/system clock
reset_n  input  1  asynchronous active-low reset
wr_valid  input  1  byte offered by CPU
wr_data  input  8  ASCII byte
wr_ready  output  1  buffer can accept a byte this cycle
x  input  10  current pixel column
y  input  10  current pixel row
video_on  input  1  visible-area flag
ascii_char  output  8  cell code for (x,y), 1-cycle latency
x_out  output  10  x delayed 1 cycle
y_out  output  10  y delayed 1 cycle
video_on_out  output  1  video_on delayed 1 cycle
cursor_col  output  7  current cursor column
cursor_row  output  5  current cursor logical row
busy  output  1  high while in CLEAR or SCROLL_CLR

Behaviour:
- Storage: COLS*ROWS x 8 single-clock RAM, one write port and one read port. Same-cycle read and write to one address is read-first (returns old data).
- Circular rows: top_row register (0..ROWS-1). Physical row = (logical row + top_row) mod ROWS; this is the wrap rule. Scrolling never copies memory.
- Read path (registered, latency 1):
  - ascii_char = RAM[phys(y[8:4]), x[9:3]] when video_on=1, x[9:3]<COLS and y[8:4]<ROWS; otherwise BLANK.
  - x_out, y_out and video_on_out are x, y and video_on registered on the same edge.
  - The read path is active in every state.
- Handshake:
  - wr_ready = (state==IDLE); busy = ~wr_ready.
  - A byte is accepted on a rising edge with wr_valid & wr_ready. Back-to-back accepts are allowed, one per cycle.
  - wr_data is ignored when not accepted.
- Byte handling on accept, IDLE only:
  - 0x20-0x7E: write the byte at (cursor_row, cursor_col), then col+1.
    - If col+1==COLS: col=0, row+1.
    - If the row was ROWS-1: row stays ROWS-1, top_row+1 mod ROWS, enter SCROLL_CLR.
  - 0x0A: col=0, then the same row advance/scroll rule.
  - 0x0D: col=0.
  - 0x08: if col>0, col-1 and write BLANK at the new col. If col==0, no effect.
  - 0x0C: enter CLEAR, top_row=0, cursor=(0,0).
  - Any other code: accepted, no effect.
- FSM:
  - IDLE.
  - SCROLL_CLR: writes BLANK to every column of the new bottom physical row, col 0..COLS-1, one cell per cycle. Exactly COLS cycles, then IDLE.
  - CLEAR: writes BLANK to all COLS*ROWS cells, one per cycle. Exactly COLS*ROWS cycles, then IDLE.
- Reset (asserted anywhere, including mid-SCROLL_CLR/CLEAR):
  - Immediate values: state=CLEAR with clear counter 0, top_row=0, cursor=(0,0), ascii_char=BLANK, x_out=0, y_out=0, video_on_out=0, wr_ready=0, busy=1.
  - After release: the full clear runs (2400 cycles), then wr_ready=1.
  - An interrupted operation is abandoned, not resumed.
- Arithmetic: all cursor and row counters saturate or wrap only as stated above. No carry into adjacent fields.

Test Plan:
- Reset release -> wr_ready=0 for exactly 2400 cycles then 1; sweep all (x,y) with video_on=1 -> ascii_char=8'h20, one cycle after each coordinate.
- Send 0x41, 0x42 back-to-back -> both accepted in 2 cycles; cursor (col 2, row 0). x=0..7/y=0..15 -> ascii_char 0x41; x=8..15 -> 0x42; x_out equals prior-cycle x.
- Send 80 x 0x2A then 0x5A -> cursor (col 1, row 1); pixel (0,16) -> 0x5A; pixel (632,0) -> 0x2A.
- Fill rows 0..29 with row index+0x30 via 0x0A separators, then send 0x0A on row 29 -> wr_ready low exactly 80 cycles. y=0 now shows row-1 content (0x31); y=464 shows 0x20; cursor (0,29).
- At col 3 send 0x08 -> col 2, cell 2 = 0x20. At col 0 send 0x08 -> no change. Send 0x0C -> 2400 busy cycles, cursor (0,0), screen all 0x20.
- Pulse reset_n low during cycle 40 of SCROLL_CLR -> outputs at reset values immediately; after release, full 2400-cycle CLEAR, top_row=0, screen blank.
